// File: rtl/cv4_layer_sequencer.sv
// Frame-level sequencer for the cv4 filter column engine: kernel load, image stream, output tagging.
// Optional perf counters (perf_cycles, perf_stalls) are built when SEQ_PERF_CNT_EN is defined.
module cv4_layer_sequencer #(
    parameter int unsigned KERNEL_SIZE   = 4,
    parameter int unsigned IMG_COLS      = 24,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned OUT_IDX_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 src_stall,
    output logic                 kmem_rd_en,
    output logic [ADDR_W-1:0]    kmem_addr,
    output logic                 imem_rd_en,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic                 filt_clr,
    output logic                 filt_kernel_load,
    output logic                 filt_valid_in,
    input  logic                 filt_valid_out,
    output logic                 out_valid,
    output logic [OUT_IDX_W-1:0] out_col_idx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_timeout
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [15:0]          perf_stalls
`endif
);

    localparam int unsigned TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int unsigned EXP   = IMG_COLS - KERNEL_SIZE;
    localparam logic [OUT_IDX_W-1:0] IDX_MAX = '1;
    localparam logic [TMR_W-1:0]     TMR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_K,
        S_GAP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [OUT_IDX_W-1:0] out_cnt;
    logic [TMR_W-1:0]     drain_tmr;
    logic                 tagging;

    // Read strobes must drop on the very cycle the source stalls, so they decode the current stall.
    assign kmem_rd_en = (state == S_LOAD_K) && !src_stall;
    assign imem_rd_en = (state == S_RUN) && !src_stall;
    assign tagging    = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            kmem_addr        <= '0;
            imem_addr        <= '0;
            filt_clr         <= 1'b0;
            filt_kernel_load <= 1'b0;
            filt_valid_in    <= 1'b0;
            out_valid        <= 1'b0;
            out_col_idx      <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            err_timeout      <= 1'b0;
            out_cnt          <= '0;
            drain_tmr        <= '0;
        end else begin
            filt_clr         <= 1'b0;
            frame_done       <= 1'b0;
            out_valid        <= 1'b0;
            // Memory data lands one cycle after the read, so the filter strobes trail by one stage.
            filt_kernel_load <= kmem_rd_en;
            filt_valid_in    <= imem_rd_en;

            if (tagging && filt_valid_out) begin
                out_valid   <= 1'b1;
                out_col_idx <= out_cnt;
                if (out_cnt != IDX_MAX) begin
                    out_cnt <= out_cnt + OUT_IDX_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    out_col_idx <= '0;
                    if (start) begin
                        state       <= S_CLEAR;
                        busy        <= 1'b1;
                        filt_clr    <= 1'b1;
                        err_timeout <= 1'b0;
                        kmem_addr   <= '0;
                        imem_addr   <= '0;
                        out_cnt     <= '0;
                        drain_tmr   <= '0;
                    end
                end
                S_CLEAR: begin
                    state <= S_LOAD_K;
                end
                S_LOAD_K: begin
                    if (kmem_rd_en) begin
                        kmem_addr <= kmem_addr + ADDR_W'(1);
                        if (kmem_addr == ADDR_W'(KERNEL_SIZE - 1)) begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (imem_rd_en) begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        if (imem_addr == ADDR_W'(IMG_COLS - 1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_tmr != TMR_MAX) begin
                        drain_tmr <= drain_tmr + TMR_W'(1);
                    end
                    // Completion wins over a timeout landing on the same cycle.
                    if ((32'(out_cnt) >= EXP) && !filt_valid_in) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else if (drain_tmr >= TMR_W'(DRAIN_TIMEOUT - 1)) begin
                        state       <= S_DONE;
                        frame_done  <= 1'b1;
                        err_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Busy-cycle and source-stall counters; restart on an accepted start, hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (state != S_IDLE) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (((state == S_LOAD_K) || (state == S_RUN)) && src_stall && (perf_stalls != 16'hFFFF)) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cv4_layer_sequencer.sv
// Directed bench for cv4_layer_sequencer with a small filter model and an output-index scoreboard.
module tb_cv4_layer_sequencer;

    localparam int unsigned KS     = 4;
    localparam int unsigned COLS   = 24;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              src_stall = 1'b0;
    logic              kmem_rd_en, imem_rd_en;
    logic [ADDR_W-1:0] kmem_addr, imem_addr;
    logic              filt_clr, filt_kernel_load, filt_valid_in;
    logic              filt_valid_out = 1'b0;
    logic              out_valid;
    logic [IDX_W-1:0]  out_col_idx;
    logic              busy, frame_done, err_timeout;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       perf_cycles;
    logic [15:0]       perf_stalls;
`endif

    cv4_layer_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .src_stall        (src_stall),
        .kmem_rd_en       (kmem_rd_en),
        .kmem_addr        (kmem_addr),
        .imem_rd_en       (imem_rd_en),
        .imem_addr        (imem_addr),
        .filt_clr         (filt_clr),
        .filt_kernel_load (filt_kernel_load),
        .filt_valid_in    (filt_valid_in),
        .filt_valid_out   (filt_valid_out),
        .out_valid        (out_valid),
        .out_col_idx      (out_col_idx),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_timeout      (err_timeout)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_stalls      (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k_reads, i_reads, outs, kl_cnt, vi_cnt, clr_cnt, done_cnt, done_base, busy_cyc;
    int last_rd_cyc, done_cyc, last_kl, first_vin;
    bit vin_seen;
    int m_in, m_out;
    int max_out = 1000;
    logic emit = 1'b0;
    logic prev_k = 1'b0, prev_c = 1'b0;
    logic [ADDR_W-1:0] exp_k, exp_c;
    logic [IDX_W-1:0]  exp_idx;
    logic [IDX_W-1:0]  q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor, scoreboard and filter model share one sampling point away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            prev_k = 1'b0;
            prev_c = 1'b0;
            emit   = 1'b0;
            m_in   = 0;
            m_out  = 0;
        end else begin
            if (filt_clr) begin
                clr_cnt++;
                exp_k = '0; exp_c = '0; exp_idx = '0;
                q.delete();
                m_in = 0; m_out = 0;
                k_reads = 0; i_reads = 0; outs = 0; kl_cnt = 0; vi_cnt = 0;
                vin_seen = 1'b0;
            end
            chk("kload_follows_rd", 32'(filt_kernel_load), 32'(prev_k));
            chk("vin_follows_rd", 32'(filt_valid_in), 32'(prev_c));
            if (filt_kernel_load || filt_valid_in)
                chk("strobe_overlap", 32'(filt_kernel_load & filt_valid_in), 32'd0);
            if (kmem_rd_en) begin
                chk("kmem_rd_in_stall", 32'(src_stall), 32'd0);
                chk("kmem_addr", 32'(kmem_addr), 32'(exp_k));
                exp_k++;
                k_reads++;
            end
            if (imem_rd_en) begin
                chk("imem_rd_in_stall", 32'(src_stall), 32'd0);
                chk("imem_addr", 32'(imem_addr), 32'(exp_c));
                exp_c++;
                i_reads++;
                last_rd_cyc = cyc;
            end
            if (filt_kernel_load) begin
                kl_cnt++;
                last_kl = cyc;
            end
            if (filt_valid_in) begin
                vi_cnt++;
                if (!vin_seen) first_vin = cyc;
                vin_seen = 1'b1;
            end
            if (out_valid) begin
                outs++;
                if (q.size() == 0) chk("out_unexpected", 32'(q.size()), 32'd1);
                else chk("out_col_idx", 32'(out_col_idx), 32'(q.pop_front()));
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cyc++;
            prev_k = kmem_rd_en;
            prev_c = imem_rd_en;
            // Filter model: one output per column once the kernel window is full, one cycle later.
            emit = 1'b0;
            if (filt_valid_in) begin
                m_in++;
                if (m_in > KS && m_out < max_out) begin
                    emit = 1'b1;
                    m_out++;
                    q.push_back(exp_idx);
                    if (exp_idx != '1) exp_idx++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        filt_valid_out = emit;
    end

    task automatic run_frame(input bit stall_mode, input int restart_at, input int rst_at,
                             input bit perf_stall, output bit got_done);
        bit restarted;
        bit aborted;
        logic [31:0] stalled;
        int i;
        restarted = 1'b0; aborted = 1'b0; stalled = '0; got_done = 1'b0;
        busy_cyc = 0; clr_cnt = 0; done_base = done_cnt;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        i = 0;
        while (!got_done && i < 400) begin
            src_stall = stall_mode && (i % 3 == 2);
            if (perf_stall && imem_addr >= 3 && imem_addr <= 15 && (imem_addr % 3 == 0)
                && !stalled[imem_addr]) begin
                src_stall = 1'b1;
                stalled[imem_addr] = 1'b1;
            end
            start = 1'b0;
            if (restart_at >= 0 && !restarted && 32'(imem_addr) == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (rst_at >= 0 && 32'(imem_addr) == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_outputs_zero",
                    32'({kmem_rd_en, kmem_addr, imem_rd_en, imem_addr, filt_clr, filt_kernel_load,
                         filt_valid_in, out_valid, out_col_idx, busy, frame_done, err_timeout}), 32'd0);
                @(negedge clk);
                @(posedge clk); #2;
                rst = 1'b0; src_stall = 1'b0; start = 1'b0;
                repeat (6) @(negedge clk);
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (frame_done) got_done = 1'b1;
            @(posedge clk); #2;
            i++;
        end
        src_stall = 1'b0;
        start = 1'b0;
        if (!aborted) chk("frame_done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int exp_outs, input bit exp_err);
        chk({tag, "_clr_pulses"}, 32'(clr_cnt), 32'd1);
        chk({tag, "_kmem_reads"}, 32'(k_reads), 32'(KS));
        chk({tag, "_kload_cycles"}, 32'(kl_cnt), 32'(KS));
        chk({tag, "_imem_reads"}, 32'(i_reads), 32'(COLS));
        chk({tag, "_vin_cycles"}, 32'(vi_cnt), 32'(COLS));
        chk({tag, "_out_count"}, 32'(outs), 32'(exp_outs));
        chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(exp_err));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_dropped"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        bit gd;
        int base;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({kmem_rd_en, kmem_addr, imem_rd_en, imem_addr, filt_clr, filt_kernel_load,
                 filt_valid_in, out_valid, out_col_idx, busy, frame_done, err_timeout}), 32'd0);
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Nominal frame
        run_frame(1'b0, -1, -1, 1'b0, gd);
        check_frame("nominal", 20, 1'b0);
        chk("nominal_kload_to_vin_gap", 32'(first_vin - last_kl), 32'd2);

        // Stalls one cycle in three
        run_frame(1'b1, -1, -1, 1'b0, gd);
        check_frame("stall", 20, 1'b0);

        // Drain timeout with a filter that emits only 10 columns
        max_out = 10;
        run_frame(1'b0, -1, -1, 1'b0, gd);
        check_frame("timeout", 10, 1'b1);
        chk("timeout_drain_len", 32'(done_cyc - last_rd_cyc), 32'd17);
        repeat (3) @(posedge clk);
        #2;
        chk("timeout_sticky", 32'(err_timeout), 32'd1);
        max_out = 1000;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        chk("err_cleared_on_start", 32'(err_timeout), 32'd0);
        repeat (60) @(posedge clk);
        #2;
        chk("post_timeout_frame_err", 32'(err_timeout), 32'd0);
        chk("post_timeout_frame_outs", 32'(outs), 32'd20);

        // Second start during RUN is ignored
        run_frame(1'b0, 7, -1, 1'b0, gd);
        check_frame("restart_ignored", 20, 1'b0);

        // Reset mid-RUN, then a clean frame
        base = done_cnt;
        run_frame(1'b0, -1, 12, 1'b0, gd);
        chk("rst_no_done", 32'(done_cnt - base), 32'd0);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        run_frame(1'b0, -1, -1, 1'b0, gd);
        check_frame("after_rst", 20, 1'b0);

`ifdef SEQ_PERF_CNT_EN
        run_frame(1'b0, -1, -1, 1'b1, gd);
        check_frame("perf", 20, 1'b0);
        chk("perf_stalls", 32'(perf_stalls), 32'd5);
        chk("perf_cycles", perf_cycles, 32'(busy_cyc));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv4_layer_sequencer.md
Name: cv4_layer_sequencer

Overview:
- Frame-level controller for one cv4 convolution filter column engine.
- On start, it fetches KERNEL_SIZE kernel columns and drives them into the filter in load mode.
- It then streams IMG_COLS image columns from the column buffer, counts the filter's output columns and tags each one with an index.
- It signals frame completion or a drain-timeout error.

Parameters:
- KERNEL_SIZE, 4, kernel width in columns; number of kernel-load beats.
- IMG_COLS, 24, input columns per frame.
- ADDR_W, 5, width of kernel/image column addresses; must satisfy 2^ADDR_W >= IMG_COLS.
- DRAIN_TIMEOUT, 16, maximum cycles spent in DRAIN before an error is flagged.
- OUT_IDX_W, 5, width of the output column index.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle frame start pulse; accepted only in IDLE.
- src_stall, input, 1, column buffer not ready; the sequencer issues no read on any cycle this is high.
- kmem_rd_en, output, 1, kernel memory read strobe.
- kmem_addr, output, ADDR_W, kernel column address.
- imem_rd_en, output, 1, image column buffer read strobe.
- imem_addr, output, ADDR_W, image column address.
- filt_clr, output, 1, one-cycle clear to the filter; OR'd with rst at top level.
- filt_kernel_load, output, 1, filter kernel_load.
- filt_valid_in, output, 1, filter valid_in.
- filt_valid_out, input, 1, filter valid_out.
- out_valid, output, 1, registered copy of filt_valid_out during RUN/DRAIN.
- out_col_idx, output, OUT_IDX_W, index of the output column presented with out_valid.
- busy, output, 1, high in any state except IDLE.
- frame_done, output, 1, one-cycle pulse when the frame completes.
- err_timeout, output, 1, sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Memories have 1-cycle read latency, and their data goes directly to the filter.
  - filt_kernel_load and filt_valid_in are therefore rd_en delayed one register stage.
  - As a result, data and strobe arrive at the filter on the same cycle.
- IDLE:
  - start -> CLEAR.
  - err_timeout cleared; out_col_idx cleared.
- CLEAR (1 cycle):
  - filt_clr=1, ensuring the filter's priming state machine starts from empty.
  - Next state LOAD_K.
- LOAD_K:
  - Each cycle with src_stall=0: kmem_rd_en=1 at kmem_addr=k, then k++.
  - After the read with k=KERNEL_SIZE-1 issues, go to GAP.
  - Delayed kernel_load strobes follow one cycle later.
  - Stall cycles produce no read and no strobe; address is held.
- GAP (1 cycle):
  - No reads, letting the last delayed kernel_load retire.
  - Guarantees that filt_kernel_load=0 before the first filt_valid_in=1.
  - The two strobes are never high together.
  - Next state RUN.
- RUN:
  - Each unstalled cycle: imem_rd_en=1 at imem_addr=c, then c++.
  - After the read with c=IMG_COLS-1, go to DRAIN.
  - Delayed filt_valid_in=1 follows each read.
- DRAIN:
  - Wait until the output count equals EXP = IMG_COLS-KERNEL_SIZE.
  - Also wait until the final delayed strobe has issued.
  - Then go to DONE.
  - If DRAIN_TIMEOUT cycles elapse first: set err_timeout=1 and go to DONE anyway.
- DONE (1 cycle): frame_done=1, then IDLE.
- Output tagging (RUN, DRAIN):
  - On filt_valid_out=1, the next cycle drives out_valid=1 with out_col_idx = current count; then the count increments.
  - filt_valid_out outside RUN/DRAIN is ignored.
  - Extra pulses beyond EXP in DRAIN are forwarded, but the index saturates at 2^OUT_IDX_W-1.
- start while busy: ignored; no restart, no error.
- Asynchronous rst mid-frame: immediate return to IDLE with all outputs 0. No frame_done pulse.
- Counter widths:
  - Address counters are ADDR_W bits.
  - The drain timer is ceil(log2(DRAIN_TIMEOUT+1)) bits and saturates.

Optional Feature:
- Macro SEQ_PERF_CNT_EN adds output perf_cycles [31:0].
- perf_cycles counts busy cycles of the current frame; it is frozen at frame_done and cleared on accepted start.
- A second output perf_stalls [15:0] counts cycles with src_stall=1 in LOAD_K/RUN; it saturates.
- Without the macro, neither port nor the counters exist.

Test Plan:
- Nominal: rst, then start, with src_stall=0 throughout, IMG_COLS=24, KERNEL_SIZE=4.
  - Required: exactly 4 kmem reads (addr 0..3), then 24 imem reads (addr 0..23).
  - filt_kernel_load is high for 4 cycles, then 1 idle cycle, then filt_valid_in is high for 24 cycles.
  - Required: 20 out_valid pulses with idx 0..19, then one frame_done.
- Stalls: src_stall toggled 1-of-3 cycles during LOAD_K/RUN.
  - Addresses stay contiguous with no duplicates.
  - Strobes have gaps exactly matching the stalls.
  - Output indices are still 0..19.
- Timeout: filter model emits only 10 valid_out pulses.
  - After 16 DRAIN cycles, err_timeout=1 and frame_done pulses.
  - The next start clears err_timeout.
- start during RUN: second start at imem_addr=7. No address reset; the frame completes normally.
- Reset mid-RUN: rst asserted at imem_addr=12.
  - All outputs go to 0 and the state goes to IDLE; no frame_done.
  - A new start runs a clean frame with a filt_clr pulse and idx from 0.
- SEQ_PERF_CNT_EN: nominal frame with 5 stall cycles. perf_stalls=5; perf_cycles equals the measured busy count.
